// File: rtl/fpu_pipe_pkg.sv
// Shared definitions for FPU inter-stage pipeline registers: mul-to-add
// payload field widths, LSB-based bit offsets and the packed payload struct.
package fpu_pipe_pkg;

    localparam int unsigned RM_W    = 2;
    localparam int unsigned EXP_W   = 10;
    localparam int unsigned FRAC_W  = 23;
    localparam int unsigned SUM_W   = 39;
    localparam int unsigned CARRY_W = 40;
    localparam int unsigned Z8_W    = 8;

    localparam int unsigned MUL_ADD_W = RM_W + 1 + EXP_W + 1 + FRAC_W + SUM_W + CARRY_W + Z8_W;

    // Offsets follow the struct below: the first struct member sits at the MSB end.
    localparam int unsigned Z8_OFF         = 0;
    localparam int unsigned CARRY_OFF      = Z8_OFF + Z8_W;
    localparam int unsigned SUM_OFF        = CARRY_OFF + CARRY_W;
    localparam int unsigned INF_NAN_FR_OFF = SUM_OFF + SUM_W;
    localparam int unsigned IS_INF_NAN_OFF = INF_NAN_FR_OFF + FRAC_W;
    localparam int unsigned EXP_OFF        = IS_INF_NAN_OFF + 1;
    localparam int unsigned SIGN_OFF       = EXP_OFF + EXP_W;
    localparam int unsigned RM_OFF         = SIGN_OFF + 1;

    typedef struct packed {
        logic [RM_W-1:0]    rm;
        logic               sign;
        logic [EXP_W-1:0]   exp10;
        logic               is_inf_nan;
        logic [FRAC_W-1:0]  inf_nan_frac;
        logic [SUM_W-1:0]   sum;
        logic [CARRY_W-1:0] carry;
        logic [Z8_W-1:0]    z8;
    } mul_add_payload_t;

endpackage

// File: rtl/fpu_pipe_stage.sv
// Elastic valid/ready pipeline register with a DEPTH-entry circular buffer,
// synchronous clear and flush. All outputs come from registered state.
module fpu_pipe_stage
    import fpu_pipe_pkg::*;
#(
    parameter int unsigned W          = MUL_ADD_W,
    parameter int unsigned DEPTH      = 2,
    parameter bit          CLEAR_DATA = 1'b1,
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // DEPTH may not be a power of two, so wrap by compare rather than overflow.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clr || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage only clears when CLEAR_DATA is set; otherwise stale payloads remain.
    always_ff @(posedge clock) begin
        if (CLEAR_DATA && (clr || flush)) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !clr && !flush) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_fpu_pipe_stage.sv
// Directed bench for fpu_pipe_stage: DEPTH=2/3/1 instances share one stimulus
// stream; each phase checks the instance it targets.
module tb_fpu_pipe_stage;
    import fpu_pipe_pkg::*;

    localparam int W = $bits(mul_add_payload_t);

    logic         clk = 1'b0;
    logic         clr, flush, in_valid, out_ready;
    logic [W-1:0] in_data;

    logic         r2, v2, r3, v3, r1, v1;
    logic [W-1:0] d2, d3, d1;
    logic [1:0]   c2, c3;
    logic [0:0]   c1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [W-1:0] sb[$];
    logic [127:0] rnd;

    always #5 clk = ~clk;

    fpu_pipe_stage #(.W(W), .DEPTH(2), .CLEAR_DATA(1'b1)) u_d2 (
        .clock(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(r2),
        .in_data(in_data), .out_valid(v2), .out_ready(out_ready), .out_data(d2), .count(c2));
    fpu_pipe_stage #(.W(W), .DEPTH(3), .CLEAR_DATA(1'b1)) u_d3 (
        .clock(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(r3),
        .in_data(in_data), .out_valid(v3), .out_ready(out_ready), .out_data(d3), .count(c3));
    fpu_pipe_stage #(.W(W), .DEPTH(1), .CLEAR_DATA(1'b1)) u_d1 (
        .clock(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(r1),
        .in_data(in_data), .out_valid(v1), .out_ready(out_ready), .out_data(d1), .count(c1));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1; flush = 1'b0; in_valid = 1'b0;
        tick();
        clr = 1'b0;
    endtask

    // Handshake invariants: never ready when full, never valid when empty.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("d2_ready_when_full", 128'(r2 && (c2 == 2'd2)), 128'd0);
            chk("d2_valid_when_empty", 128'(v2 && (c2 == 2'd0)), 128'd0);
            chk("d3_ready_when_full", 128'(r3 && (c3 == 2'd3)), 128'd0);
            chk("d1_ready_when_full", 128'(r1 && (c1 == 1'b1)), 128'd0);
        end
    end

    initial begin
        clr = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

        // Reset held two cycles, then released idle.
        tick(); tick();
        clr = 1'b0;
        tick();
        mon_en = 1'b1;
        chk("rst_count", 128'(c2), 128'd0);
        chk("rst_out_valid", 128'(v2), 128'd0);
        chk("rst_in_ready", 128'(r2), 128'd1);
        chk("rst_out_data", 128'(d2), 128'd0);
        chk("rst_d3_count", 128'(c3), 128'd0);
        chk("rst_d1_ready", 128'(r1), 128'd1);

        // DEPTH=2 streaming with downstream always ready.
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = W'(i);
            tick();
            chk("stream_data", 128'(d2), 128'(i));
            chk("stream_valid", 128'(v2), 128'd1);
            chk("stream_count", 128'(c2), 128'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained", 128'(c2), 128'd0);
        chk("stream_drained_valid", 128'(v2), 128'd0);

        // DEPTH=2 backpressure: fill, hold off third, then drain in order.
        do_clr();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = W'(32'hA); tick();
        chk("bp_count1", 128'(c2), 128'd1);
        chk("bp_ready1", 128'(r2), 128'd1);
        in_data = W'(32'hB); tick();
        chk("bp_count2", 128'(c2), 128'd2);
        chk("bp_ready_full", 128'(r2), 128'd0);
        in_data = W'(32'hC); tick();
        chk("bp_held_count", 128'(c2), 128'd2);
        chk("bp_held_head", 128'(d2), 128'hA);
        out_ready = 1'b1; tick();
        chk("bp_pop_a", 128'(d2), 128'hB);
        chk("bp_pop_a_count", 128'(c2), 128'd1);
        tick();
        chk("bp_c_head", 128'(d2), 128'hC);
        chk("bp_c_count", 128'(c2), 128'd1);
        in_valid = 1'b0; tick();
        chk("bp_empty", 128'(v2), 128'd0);

        // Flush while full with a concurrent in_valid, then while partly full.
        do_clr();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = W'(32'h11); tick();
        in_data = W'(32'h22); tick();
        chk("fl_full", 128'(c2), 128'd2);
        flush = 1'b1; in_data = W'(32'h55); tick();
        chk("fl_count", 128'(c2), 128'd0);
        chk("fl_valid", 128'(v2), 128'd0);
        chk("fl_ready", 128'(r2), 128'd1);
        chk("fl_zeroed", 128'(d2), 128'd0);
        flush = 1'b0; in_valid = 1'b0; tick();
        chk("fl_no55_count", 128'(c2), 128'd0);
        chk("fl_no55_data", 128'(d2), 128'd0);
        in_valid = 1'b1; in_data = W'(32'h77); tick();
        chk("fl_push77", 128'(d2), 128'h77);
        flush = 1'b1; in_data = W'(32'h66); tick();
        chk("fl2_count", 128'(c2), 128'd0);
        chk("fl2_zeroed", 128'(d2), 128'd0);
        flush = 1'b0; in_valid = 1'b0; tick();
        chk("fl2_no66", 128'(v2), 128'd0);

        // DEPTH=3 random traffic against an in-order scoreboard.
        do_clr();
        sb.delete();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (!(in_valid && !r3)) begin
                in_valid = 1'($urandom_range(0, 1));
                rnd = {$urandom, $urandom, $urandom, $urandom};
                in_data = rnd[W-1:0];
            end
            out_ready = 1'($urandom_range(0, 1));
            if (v3 && out_ready) begin
                if (sb.size() == 0) chk("rnd_spurious_valid", 128'(v3), 128'd0);
                else chk("rnd_order", 128'(d3), 128'(sb.pop_front()));
            end
            if (in_valid && r3) sb.push_back(in_data);
            tick();
            chk("rnd_count", 128'(c3), 128'(sb.size()));
        end

        // DEPTH=1: one transfer every second cycle, then clr mid-transfer.
        do_clr();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = W'(32'h100 + i);
            tick();
            chk("d1_accept_valid", 128'(v1), 128'd1);
            chk("d1_accept_data", 128'(d1), 128'(32'h100 + i));
            chk("d1_busy", 128'(r1), 128'd0);
            tick();
            chk("d1_gap_valid", 128'(v1), 128'd0);
            chk("d1_gap_ready", 128'(r1), 128'd1);
        end
        in_data = W'(32'h200); tick();
        chk("d1_pre_clr", 128'(v1), 128'd1);
        clr = 1'b1; tick();
        chk("d1_clr_valid", 128'(v1), 128'd0);
        chk("d1_clr_count", 128'(c1), 128'd0);
        chk("d1_clr_data", 128'(d1), 128'd0);
        clr = 1'b0; in_valid = 1'b0; tick();
        chk("d1_discarded", 128'(v1), 128'd0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
